button_debounce: RTL and testbench



---
 rtl/button_pkg.sv | 19 +
 rtl/sync_2ff.sv | 26 ++
 rtl/button_debounce.sv | 81 ++++++++
 tb/tb_button_debounce.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and timing constants for the push-button front end.
package button_pkg;

    typedef enum logic [1:0] {
        REL    = 2'b00,
        WAIT_P = 2'b01,
        PRS    = 2'b10,
        WAIT_R = 2'b11
    } state_t;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

    // Debounce windows are usually quoted in ms; convert at elaboration time.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return ms * CYCLES_PER_MS;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop resynchronizer for asynchronous switch/button inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop sync followed by a stable-time qualification FSM.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic KeyRaw,
    output logic Bd,
    output logic Settling
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s2;
    logic             w_lvl;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_bd;
    logic             r_settling;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (KeyRaw),
        .q     (w_s2)
    );

    assign w_lvl = ACTIVE_LOW ? ~w_s2 : w_s2;

    // Next state; the counter defaults to zero so every state entry clears it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            REL: begin
                if (w_lvl) w_state_nxt = WAIT_P;
            end
            WAIT_P: begin
                if (!w_lvl)                 w_state_nxt = REL;
                else if (r_cnt == CNT_LAST) w_state_nxt = PRS;
                else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            PRS: begin
                if (!w_lvl) w_state_nxt = WAIT_R;
            end
            WAIT_R: begin
                if (w_lvl)                  w_state_nxt = PRS;
                else if (r_cnt == CNT_LAST) w_state_nxt = REL;
                else                        w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            default: w_state_nxt = REL;
        endcase
    end

    // Outputs are registered decodes of the next state, so they track r_state exactly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= REL;
            r_cnt      <= '0;
            r_bd       <= 1'b0;
            r_settling <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bd       <= (w_state_nxt == PRS)    || (w_state_nxt == WAIT_R);
            r_settling <= (w_state_nxt == WAIT_P) || (w_state_nxt == WAIT_R);
        end
    end

    assign Bd       = r_bd;
    assign Settling = r_settling;

endmodule

// File: tb/tb_button_debounce.sv
// Debouncer bench: run-length reference model checked every cycle, plus directed literal checks.
module tb_button_debounce;

    localparam int unsigned SC = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst   = 1'b1;
    logic press = 1'b0;
    logic key_l;
    logic key_h;
    logic bd_l, st_l, bd_h, st_h;

    assign key_l = ~press;
    assign key_h = press;

    button_debounce #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) u_dut_al (
        .Clk      (clk),
        .Reset    (rst),
        .KeyRaw   (key_l),
        .Bd       (bd_l),
        .Settling (st_l)
    );

    button_debounce #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .Clk      (clk),
        .Reset    (rst),
        .KeyRaw   (key_h),
        .Bd       (bd_h),
        .Settling (st_h)
    );

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pressed level delayed two cycles, then a run-length rule --
    // the output flips once the delayed level has differed from it for SC+1 edges.
    logic m_p1  = 1'b0;
    logic m_p2  = 1'b0;
    logic m_bd  = 1'b0;
    int   m_run = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_p1  <= 1'b0;
            m_p2  <= 1'b0;
            m_bd  <= 1'b0;
            m_run <= 0;
        end else begin
            m_p1 <= press;
            m_p2 <= m_p1;
            if (m_p2 != m_bd) begin
                if (m_run == int'(SC)) begin
                    m_bd  <= m_p2;
                    m_run <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_bd_al1",  bd_l, m_bd);
            check("model_set_al1", st_l, m_run != 0);
            check("model_bd_al0",  bd_h, m_bd);
            check("model_set_al0", st_h, m_run != 0);
        end
    end

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic exp_bd, input logic exp_st);
        check({name, "_bd_al1"},  bd_l, exp_bd);
        check({name, "_set_al1"}, st_l, exp_st);
        check({name, "_bd_al0"},  bd_h, exp_bd);
        check({name, "_set_al0"}, st_h, exp_st);
    endtask

    initial begin
        // Reset held 3 cycles with the key released.
        for (int i = 0; i < 3; i++) begin
            adv();
            cmp_en = 1'b1;
            lit("reset", 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adv();
            lit("idle", 1'b0, 1'b0);
        end

        // Clean press: first sampled at edge k (i=0); Bd at k+6.
        press = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            adv();
            lit("press", i >= 6, (i >= 2) && (i <= 5));
        end

        // Release bounce from PRS: released 3, pressed 1, released steady.
        for (int i = 0; i <= 11; i++) begin
            press = (i == 3);
            adv();
            lit("relbounce", i < 10, ((i >= 2) && (i <= 4)) || ((i >= 6) && (i <= 9)));
        end

        // Press bounce from REL: pressed 2, released 1, pressed 2, released.
        for (int i = 0; i <= 11; i++) begin
            press = (i < 2) || (i == 3) || (i == 4);
            adv();
            lit("pressbounce", 1'b0, (i == 2) || (i == 3) || (i == 5) || (i == 6));
        end

        // Reset in WAIT_P with cnt=2, key kept pressed; press re-qualified afterwards.
        press = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            adv();
        end
        lit("midwait", 1'b0, 1'b1);
        rst = 1'b1;
        adv();
        lit("midreset", 1'b0, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            adv();
            lit("requal", n >= 7, (n >= 3) && (n <= 6));
        end

        // Reset while pressed, then a clean release qualifies from REL silence.
        rst = 1'b1;
        press = 1'b0;
        adv();
        lit("prsreset", 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adv();
            lit("tail", 1'b0, 1'b0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
